// File: rtl/core_pkg.sv
// Shared fetch-stage types and default widths for the pipelined core.
package core_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned      ADDR_W_DEF   = 32;
    localparam int unsigned      INSTR_W_DEF  = 32;
    localparam int unsigned      PC_STEP_DEF  = 4;
    localparam logic [31:0]      RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load on enable, flush clears valid, async reset.
module if_id_reg #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  d_pc,
    input  logic [INSTR_W-1:0] d_instr,
    output logic [ADDR_W-1:0]  q_pc,
    output logic [INSTR_W-1:0] q_instr,
    output logic               q_valid
);

    // Flush only marks the entry as a bubble; pc/instr keep their last contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_pc    <= '0;
            q_instr <= '0;
            q_valid <= 1'b0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (en) begin
            q_pc    <= d_pc;
            q_instr <= d_instr;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, handshakes with instruction memory,
// and feeds the IF/ID register with stall and branch-redirect handling.
module fetch_controller
    import core_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        INSTR_W  = INSTR_W_DEF,
    parameter int unsigned        PC_STEP  = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_valid
);

    fetch_state_t       state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next, pc_inc;
    logic [ADDR_W-1:0]  target, target_next;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               skid_load;
    logic               id_load, id_flush;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;

    // Wraps modulo 2^ADDR_W by truncation.
    assign pc_inc    = pc + ADDR_W'(PC_STEP);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            target     <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            target <= target_next;
            if (skid_load) begin
                skid_pc    <= pc_inc;
                skid_instr <= imem_rdata;
            end
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        target_next = target;
        skid_load   = 1'b0;
        id_load     = 1'b0;
        id_flush    = 1'b0;
        id_pc       = pc_inc;
        id_instr    = imem_rdata;
        imem_req    = 1'b1;
        case (state)
            S_REQ: begin
                if (imem_ready) begin
                    if (branch_taken) begin
                        pc_next  = branch_addr;
                        id_flush = 1'b1;
                    end else if (!freeze) begin
                        id_load = 1'b1;
                        pc_next = pc_inc;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = S_HOLD;
                    end
                end else if (branch_taken) begin
                    // Request in flight: keep the address, redirect once it completes.
                    target_next = branch_addr;
                    id_flush    = 1'b1;
                    state_next  = S_DRAIN;
                end else if (!freeze) begin
                    id_flush = 1'b1;
                end
            end
            S_HOLD: begin
                imem_req = 1'b0;
                if (branch_taken) begin
                    pc_next    = branch_addr;
                    id_flush   = 1'b1;
                    state_next = S_REQ;
                end else if (!freeze) begin
                    id_load    = 1'b1;
                    id_pc      = skid_pc;
                    id_instr   = skid_instr;
                    pc_next    = skid_pc;
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                id_flush = 1'b1;
                if (branch_taken) begin
                    target_next = branch_addr;
                end
                if (imem_ready) begin
                    pc_next    = branch_taken ? branch_addr : target;
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .en      (id_load),
        .flush   (id_flush),
        .d_pc    (id_pc),
        .d_instr (id_instr),
        .q_pc    (if_pc),
        .q_instr (if_instr),
        .q_valid (if_valid)
    );

endmodule
